program_run_controller: RTL and testbench
=========================================

Name: program_run_controller

Overview:
Sequences the single-cycle computer through a load → run → check cycle without testbench hierarchy pokes.
- Holds the CPU in reset.
- Streams program words into instruction memory over a valid/ready port.
- Releases the CPU and counts its cycles.
- Detects the completion store (memwrite to DONE_ADDR).
- Reports pass/fail/timeout, then freezes the CPU.
- Sits beside the computer top level, driving the CPU reset and the imem write port, and snooping the dmem bus.

Parameters:
n, 32, data/instruction word width
IMEM_WORDS, 64, instruction memory depth in words (power of 2)
DONE_ADDR, 84, dmem byte address whose store marks program completion
EXPECT, 32'h96, expected value of the completion store
MAX_CYCLES, 4096, run-cycle budget before timeout (≥2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: begin load (accepted in IDLE, DONE, FAULT only)
abort  in  1  return to IDLE from any state
load_valid  in  1  program word offered
load_ready  out  1  controller accepts word
load_data  in  n  program word
load_last  in  1  offered word is final
imem_we  out  1  instruction memory write enable
imem_addr  out  $clog2(IMEM_WORDS)  word index to write
imem_wdata  out  n  word to write
cpu_reset  out  1  reset to CPU/computer
cpu_memwrite  in  1  snooped dmem write enable
cpu_dataadr  in  n  snooped dmem byte address
cpu_writedata  in  n  snooped dmem write data
busy  out  1  state is LOAD or RUN
done  out  1  completion store seen
pass  out  1  done and result==EXPECT
timeout  out  1  run budget exhausted
overflow  out  1  program exceeded IMEM_WORDS
result  out  n  captured completion-store data
cycle_count  out  32  CPU cycles executed in the last/current run

Behaviour:
- Reset (async, immediate):
  - State IDLE, cpu_reset=1.
  - load_ready, imem_we, busy, done, pass, timeout, overflow = 0.
  - imem_addr, result, cycle_count = 0.
- States: IDLE, LOAD, RUN, DONE, FAULT. All outputs registered except:
  - load_ready = (state==LOAD).
  - imem_we = load_valid & load_ready, with imem_wdata = load_data, combinational.
  - imem_addr = word pointer register.
- Idle, done and fault entry:
  - IDLE: cpu_reset=1. start → LOAD, pointer=0, clear done/pass/timeout/overflow/result/cycle_count.
  - DONE and FAULT: hold all flags, cpu_reset=1. start → LOAD with the same clears.
- LOAD (cpu_reset=1). Each accepted word (valid&ready) writes imem[pointer].
  - Accepted word with load_last → RUN next cycle; cpu_reset falls on the RUN entry edge.
  - Accepted word without load_last → pointer+1.
  - Word accepted at pointer==IMEM_WORDS-1 without load_last → FAULT, overflow=1. That word is still written; the pointer does not wrap.
  - Zero accepted words: stay in LOAD indefinitely; start is ignored here.
- RUN (cpu_reset=0). cycle_count increments every clock.
  - Completion: cpu_memwrite & cpu_dataadr==DONE_ADDR.
    - result ← cpu_writedata, done=1, pass=(cpu_writedata==EXPECT).
    - → DONE; cpu_reset=1 next cycle. The completing cycle is counted.
  - Timeout: cycle_count==MAX_CYCLES-1 on a non-completion cycle → FAULT, timeout=1. cycle_count ends at MAX_CYCLES.
  - Completion and timeout in the same cycle: completion wins.
  - Stores to other addresses are ignored.
- abort: highest priority below reset. → IDLE next cycle, cpu_reset=1, flags cleared, pointer=0.
- start asserted in LOAD or RUN is ignored.
- Latency:
  - start → load_ready high: 1 cycle.
  - last accepted word → cpu_reset low: 1 cycle.
  - completion store → done high: 1 cycle.
- Widths: address compare uses full n bits. cycle_count saturates at 2^32-1, which is unreachable when MAX_CYCLES < 2^32.

Decomposition:
- Shared package ctrl_pkg holds:
  - ctrl_state_t enum {IDLE, LOAD, RUN, DONE, FAULT}.
  - Default DONE_ADDR/EXPECT localparams, so testbenches and the controller agree.
- One sub-module: run_timer, a 32-bit clearable enable-counter with a terminal-count compare against MAX_CYCLES-1. It produces cycle_count and the tc flag.
- The FSM, pointer and snoop logic stay in the top module.

Test Plan:
1. Load 3 words (0x20080005, 0x20090003, 0xAC080054) with last on the 3rd → imem_we pulses at addr 0,1,2 with matching wdata; cpu_reset drops exactly 1 cycle after the 3rd accept; busy=1.
2. In RUN, drive memwrite with adr=84, data=0x96 on run cycle 10 → done=1, pass=1, result=0x96, cycle_count=10, cpu_reset=1 next cycle; a store to adr 80 earlier causes no change.
3. Same as 2 with data=0x95 → done=1, pass=0, result=0x95.
4. MAX_CYCLES=16, no completion store → timeout=1 after 16 run cycles, state FAULT, cycle_count=16, cpu_reset=1; a completion store on cycle 16 instead gives done=1, timeout=0.
5. IMEM_WORDS=4, stream 5 words with no last → 4 writes (addr 0..3), overflow=1 after the 4th, load_ready=0 thereafter, cpu_reset never drops.
6. Assert abort mid-LOAD, then reset mid-RUN → each returns to IDLE with cpu_reset=1, all flags 0, cycle_count=0; a following start plus a 1-word load reruns normally.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and default constants for the program run controller and any
// bench that drives it.
//   ctrl_state_t       : controller state encoding (IDLE, LOAD, RUN, DONE, FAULT)
//   DEFAULT_DONE_ADDR  : dmem byte address whose store marks completion
//   DEFAULT_EXPECT     : expected value of the completion store
//   is_settled()       : true in the states where a new start is accepted
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } ctrl_state_t;

    localparam logic [31:0] DEFAULT_DONE_ADDR  = 32'd84;
    localparam logic [31:0] DEFAULT_EXPECT     = 32'h0000_0096;
    localparam int          DEFAULT_IMEM_WORDS = 64;
    localparam int          DEFAULT_MAX_CYCLES = 4096;

    // A start request is honoured only once the controller is parked.
    function automatic logic is_settled(input ctrl_state_t s);
        logic r;
        case (s)
            IDLE, DONE, FAULT: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/run_timer.sv
// ---------------------------------------------------------------------------
// run_timer
// 32-bit clearable enable-counter with a terminal-count flag.
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous active-high reset (count -> 0)
//   i_clr    : synchronous clear, wins over i_en
//   i_en     : count this cycle
//   o_count  : registered count, saturates at 2^32-1
//   o_tc     : count currently equals MAX_CYCLES-1
// ---------------------------------------------------------------------------
module run_timer #(
    parameter int MAX_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [31:0] o_count,
    output logic        o_tc
);

    localparam logic [31:0] TC_VALUE = 32'(MAX_CYCLES - 1);

    logic [31:0] r_count;

    // Cycle counter: clear has priority, then saturating increment.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= 32'd0;
        end else if (i_clr) begin
            r_count <= 32'd0;
        end else if (i_en && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == TC_VALUE);

endmodule

// File: rtl/program_run_controller.sv
// ---------------------------------------------------------------------------
// program_run_controller
// Drives a single-cycle computer through load -> run -> check: holds the CPU
// in reset while streaming a program into imem, releases it, counts cycles,
// snoops dmem for the completion store and reports pass/fail/timeout.
//   clk, reset                 : clock and async active-high reset
//   start, abort               : begin a load / return to IDLE
//   load_valid/ready/data/last : program word stream (valid/ready)
//   imem_we/addr/wdata         : instruction memory write port
//   cpu_reset                  : reset to the computer
//   cpu_memwrite/dataadr/writedata : snooped dmem bus
//   busy, done, pass, timeout, overflow, result, cycle_count : status
// ---------------------------------------------------------------------------
module program_run_controller
    import ctrl_pkg::*;
#(
    parameter int          n          = 32,
    parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS,
    parameter logic [n-1:0] DONE_ADDR = n'(DEFAULT_DONE_ADDR),
    parameter logic [n-1:0] EXPECT    = n'(DEFAULT_EXPECT),
    parameter int          MAX_CYCLES = DEFAULT_MAX_CYCLES,
    localparam int         AW         = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [n-1:0]  load_data,
    input  logic          load_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [n-1:0]  imem_wdata,
    output logic          cpu_reset,
    input  logic          cpu_memwrite,
    input  logic [n-1:0]  cpu_dataadr,
    input  logic [n-1:0]  cpu_writedata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic          overflow,
    output logic [n-1:0]  result,
    output logic [31:0]   cycle_count
);

    localparam logic [AW-1:0] LAST_PTR = AW'(IMEM_WORDS - 1);

    ctrl_state_t   r_state;
    logic [AW-1:0] r_ptr;
    logic          r_cpu_reset;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic          r_timeout;
    logic          r_overflow;
    logic [n-1:0]  r_result;

    logic          w_ready;
    logic          w_accept;
    logic          w_complete;
    logic          w_start_ok;
    logic          w_tc;
    logic [31:0]   w_cycle_count;

    assign w_ready    = (r_state == LOAD);
    assign w_accept   = load_valid & w_ready;
    assign w_complete = cpu_memwrite & (cpu_dataadr == DONE_ADDR);
    assign w_start_ok = start & is_settled(r_state);

    // Abort and a fresh start both zero the count; it only advances in RUN.
    run_timer #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_run_timer (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clr   (abort | w_start_ok),
        .i_en    (r_state == RUN),
        .o_count (w_cycle_count),
        .o_tc    (w_tc)
    );

    // Controller FSM with word pointer, CPU reset and captured status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_result    <= '0;
        end else if (abort) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cpu_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE, FAULT: begin
                    r_cpu_reset <= 1'b1;
                    if (start) begin
                        r_state    <= LOAD;
                        r_busy     <= 1'b1;
                        r_ptr      <= '0;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_overflow <= 1'b0;
                        r_result   <= '0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                LOAD: begin
                    r_cpu_reset <= 1'b1;
                    if (w_accept) begin
                        if (load_last) begin
                            // CPU leaves reset on the same edge that enters RUN.
                            r_state     <= RUN;
                            r_cpu_reset <= 1'b0;
                        end else if (r_ptr == LAST_PTR) begin
                            // Word at the top slot was written; no room for more.
                            r_state    <= FAULT;
                            r_overflow <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_ptr <= r_ptr + AW'(1);
                        end
                    end else begin
                        r_state <= LOAD;
                    end
                end
                RUN: begin
                    if (w_complete) begin
                        // Completion outranks a coincident budget expiry.
                        r_state     <= DONE;
                        r_result    <= cpu_writedata;
                        r_done      <= 1'b1;
                        r_pass      <= (cpu_writedata == EXPECT);
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (w_tc) begin
                        r_state     <= FAULT;
                        r_timeout   <= 1'b1;
                        r_cpu_reset <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_cpu_reset <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cpu_reset <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready  = w_ready;
    assign imem_we     = w_accept;
    assign imem_addr   = r_ptr;
    assign imem_wdata  = load_data;
    assign cpu_reset   = r_cpu_reset;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign timeout     = r_timeout;
    assign overflow    = r_overflow;
    assign result      = r_result;
    assign cycle_count = w_cycle_count;

endmodule

// File: tb/tb_program_run_controller.sv
// ---------------------------------------------------------------------------
// tb_program_run_controller
// Scoreboard bench: the stimulus process derives the expected imem writes and
// the expected end-of-run report from the program length, the last flag and
// the chosen run outcome, and queues them; a negedge monitor pops and compares
// whenever the DUT writes imem or raises a done/timeout/overflow report.
// ---------------------------------------------------------------------------
module tb_program_run_controller;

    localparam int          IMW   = 4;
    localparam int          MAXC  = 16;
    localparam logic [31:0] DADDR = 32'd84;
    localparam logic [31:0] EXP   = 32'h96;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] load_data = 32'd0;
    logic        load_last = 1'b0;
    logic        imem_we;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        cpu_memwrite = 1'b0;
    logic [31:0] cpu_dataadr = 32'd0;
    logic [31:0] cpu_writedata = 32'd0;
    logic        busy, done, pass, timeout, overflow;
    logic [31:0] result, cycle_count;

    program_run_controller #(
        .n          (32),
        .IMEM_WORDS (IMW),
        .DONE_ADDR  (DADDR),
        .EXPECT     (EXP),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .load_last     (load_last),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .cpu_reset     (cpu_reset),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_dataadr   (cpu_dataadr),
        .cpu_writedata (cpu_writedata),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .overflow      (overflow),
        .result        (result),
        .cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        cr;
        logic        d;
        logic        p;
        logic        t;
        logic        o;
        logic [31:0] res;
        logic [31:0] cnt;
    } end_t;

    wr_t  q_wr[$];
    end_t q_end[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: compare every imem write and every new end-of-run report.
    logic prev_flag = 1'b0;
    logic mon_flag;
    wr_t  mon_wr;
    end_t mon_act, mon_exp;
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            checks++;
            if (q_wr.size() == 0) begin
                errors++;
                $display("FAIL imem_write unexpected addr=%0d data=%h", imem_addr, imem_wdata);
            end else begin
                mon_wr = q_wr.pop_front();
                if ({30'd0, imem_addr, imem_wdata} !== {mon_wr.addr, mon_wr.data}) begin
                    errors++;
                    $display("FAIL imem_write actual addr=%0d data=%h expected addr=%0d data=%h",
                             imem_addr, imem_wdata, mon_wr.addr, mon_wr.data);
                end
            end
        end
        mon_flag = done | timeout | overflow;
        if (mon_flag === 1'b1 && prev_flag !== 1'b1) begin
            mon_act.cr  = cpu_reset;
            mon_act.d   = done;
            mon_act.p   = pass;
            mon_act.t   = timeout;
            mon_act.o   = overflow;
            mon_act.res = result;
            mon_act.cnt = cycle_count;
            checks++;
            if (q_end.size() == 0) begin
                errors++;
                $display("FAIL end_report unexpected cr=%b d=%b p=%b t=%b o=%b res=%h cnt=%0d",
                         mon_act.cr, mon_act.d, mon_act.p, mon_act.t, mon_act.o, mon_act.res, mon_act.cnt);
            end else begin
                mon_exp = q_end.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL end_report actual cr=%b d=%b p=%b t=%b o=%b res=%h cnt=%0d expected cr=%b d=%b p=%b t=%b o=%b res=%h cnt=%0d",
                             mon_act.cr, mon_act.d, mon_act.p, mon_act.t, mon_act.o, mon_act.res, mon_act.cnt,
                             mon_exp.cr, mon_exp.d, mon_exp.p, mon_exp.t, mon_exp.o, mon_exp.res, mon_exp.cnt);
                end
            end
        end
        prev_flag = mon_flag;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status after abort / reset: parked in IDLE, everything cleared.
    task automatic chk_idle(input string nm);
        chk({nm, "_flags"}, {57'd0, load_ready, busy, done, pass, timeout, overflow, cpu_reset}, 64'h1);
        chk({nm, "_count"}, {32'd0, cycle_count}, 64'd0);
        chk({nm, "_result"}, {32'd0, result}, 64'd0);
        chk({nm, "_addr"}, {62'd0, imem_addr}, 64'd0);
    endtask

    // One load/run transaction. mode: 0 completion at cycle c, 1 no completion,
    // 2 abort at run cycle c, 3 async reset during run cycle c.
    task automatic run_iter(input int L, input bit with_last, input int mode,
                            input int c, input logic [31:0] cdata, input bit fixed_prog);
        logic [31:0] prog[6];
        logic [31:0] fixed_words[3];
        bit   ovf, runs, acc, cr_before;
        int   nwr, r;
        end_t e;
        fixed_words[0] = 32'h2008_0005;
        fixed_words[1] = 32'h2009_0003;
        fixed_words[2] = 32'hAC08_0054;
        for (int i = 0; i < 6; i++)
            prog[i] = (fixed_prog && i < 3) ? fixed_words[i] : $urandom;

        // Reference outcome of the load phase.
        runs = with_last && (L <= IMW);
        ovf  = (!with_last && L >= IMW) || (with_last && L > IMW);
        nwr  = (L < IMW) ? L : IMW;
        for (int i = 0; i < nwr; i++) q_wr.push_back('{addr: 32'(i), data: prog[i]});
        if (ovf) begin
            e = '{cr: 1'b1, d: 1'b0, p: 1'b0, t: 1'b0, o: 1'b1, res: 32'd0, cnt: 32'd0};
            q_end.push_back(e);
        end

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_status", {57'd0, load_ready, busy, cpu_reset, done, timeout, overflow, 1'b0}, 64'h70);
        chk("start_count", {32'd0, cycle_count}, 64'd0);

        cr_before = 1'b0;
        for (int i = 0; i < L; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = with_last && (i == L - 1);
            if (i >= nwr) begin
                repeat (4) tick();
                chk("post_ovf_ready", {63'd0, load_ready}, 64'd0);
                chk("post_ovf_cpu_reset", {63'd0, cpu_reset}, 64'd1);
                break;
            end
            if (i == 1) start = 1'($urandom % 2);
            acc = 1'b0;
            for (int w = 0; w < 20 && !acc; w++) begin
                @(negedge clk);
                acc = load_ready;
                cr_before = cpu_reset;
                tick();
                start = 1'b0;
            end
            if (!acc) begin
                chk("accept_wait", 64'd0, 64'd1);
                break;
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;

        if (!runs && !ovf) begin
            repeat (3) tick();
            chk("stuck_load", {61'd0, cpu_reset, load_ready, busy}, 64'h7);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk_idle("abort_load");
        end else if (runs) begin
            chk("cpu_reset_before_run", {63'd0, cr_before}, 64'd1);
            chk("cpu_reset_run_entry", {63'd0, cpu_reset}, 64'd0);
            chk("busy_run", {63'd0, busy}, 64'd1);
            if (mode == 0) begin
                e = '{cr: 1'b1, d: 1'b1, p: (cdata == EXP), t: 1'b0, o: 1'b0, res: cdata, cnt: 32'(c)};
                q_end.push_back(e);
            end else if (mode == 1) begin
                e = '{cr: 1'b1, d: 1'b0, p: 1'b0, t: 1'b1, o: 1'b0, res: 32'd0, cnt: 32'(MAXC)};
                q_end.push_back(e);
            end
            for (int k = 1; k <= ((mode == 1) ? MAXC : c); k++) begin
                cpu_memwrite  = 1'b0;
                cpu_dataadr   = $urandom;
                cpu_writedata = $urandom;
                if (mode == 0 && k == c) begin
                    cpu_memwrite  = 1'b1;
                    cpu_dataadr   = DADDR;
                    cpu_writedata = cdata;
                end else if (mode == 2 && k == c) begin
                    abort = 1'b1;
                end else if (mode == 3 && k == c) begin
                    #2;
                    reset = 1'b1;
                    #1;
                    chk_idle("async_reset");
                end else begin
                    if (cpu_dataadr == DADDR) cpu_dataadr = 32'd0;
                    r = $urandom % 4;
                    if (k == 5 || r == 0) begin
                        cpu_memwrite = 1'b1;
                        case ($urandom % 3)
                            0:       cpu_dataadr = 32'd80;
                            1:       cpu_dataadr = DADDR | 32'h8000_0000;
                            default: cpu_dataadr = DADDR + 32'd4;
                        endcase
                        cpu_writedata = EXP;
                    end else if (r == 1) begin
                        cpu_dataadr   = DADDR;
                        cpu_writedata = EXP;
                    end else if (r == 2) begin
                        start = 1'b1;
                    end
                end
                tick();
                cpu_memwrite = 1'b0;
                start = 1'b0;
                abort = 1'b0;
                reset = 1'b0;
            end
            if (mode >= 2) chk_idle((mode == 2) ? "abort_run" : "reset_run");
        end

        repeat (2) tick();
        chk("wr_queue_left", 64'(q_wr.size()), 64'd0);
        chk("end_queue_left", 64'(q_end.size()), 64'd0);
        q_wr.delete();
        q_end.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int mode, c, L;
        bit wl;
        logic [31:0] cd;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {56'd0, load_ready, imem_we, busy, done, pass, timeout, overflow, cpu_reset}, 64'h1);
        chk("reset_values", {result, cycle_count}, 64'd0);
        chk("reset_addr", {62'd0, imem_addr}, 64'd0);
        reset = 1'b0;
        tick();
        chk_idle("idle_after_reset");

        run_iter(3, 1'b1, 0, 10, 32'h96, 1'b1);
        run_iter(3, 1'b1, 0, 10, 32'h95, 1'b1);
        run_iter(1, 1'b1, 1, 0, 32'd0, 1'b0);
        run_iter(2, 1'b1, 0, 16, 32'h96, 1'b0);
        run_iter(5, 1'b0, 0, 0, 32'd0, 1'b0);
        run_iter(4, 1'b0, 0, 0, 32'd0, 1'b0);
        run_iter(4, 1'b1, 0, 7, 32'h96, 1'b0);
        run_iter(2, 1'b0, 0, 0, 32'd0, 1'b0);
        run_iter(1, 1'b1, 0, 3, 32'h96, 1'b0);
        run_iter(2, 1'b1, 3, 4, 32'd0, 1'b0);
        run_iter(1, 1'b1, 0, 1, 32'h96, 1'b0);
        run_iter(3, 1'b1, 2, 6, 32'd0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            L  = $urandom_range(1, 6);
            wl = ($urandom % 4) != 0;
            case ($urandom % 8)
                0, 1, 2, 3: mode = 0;
                4, 5:       mode = 1;
                6:          mode = 2;
                default:    mode = 3;
            endcase
            c  = (mode == 0) ? $urandom_range(1, MAXC) : $urandom_range(1, 10);
            cd = ($urandom % 2) ? EXP : $urandom;
            run_iter(L, wl, mode, c, cd, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
